btb_nway_predictor: RTL and testbench
=====================================

Name: btb_nway_predictor

Overview:
- Parametrised N-way set-associative branch target buffer with per-entry 2-bit direction counters and true-LRU replacement.
- Sits in the fetch stage. A lookup PC presented in cycle N yields hit, predicted target and taken prediction in cycle N+1.
- A separate update port, driven from branch resolution in EX, allocates and trains entries. A flush input clears the whole table.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- INDEX_WIDTH, 4, set index bits; DEPTH = 2**INDEX_WIDTH sets.
- ASSOCIATIVITY, 4, ways per set; power of two, >= 2.
- CTR_WIDTH, 2, saturating direction counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  invalidate all entries.
- i_lookup_valid  in  1  lookup request this cycle.
- i_lookup_pc  in  ADDR_WIDTH  fetch PC to look up.
- o_hit  out  1  registered; lookup from previous cycle hit.
- o_pred_taken  out  1  registered; hit AND counter MSB set.
- o_target  out  ADDR_WIDTH  registered; target of hitting way, 0 on miss.
- o_hit_way  out  $clog2(ASSOCIATIVITY)  registered; hitting way index, 0 on miss.
- i_update_valid  in  1  resolved branch update this cycle.
- i_update_pc  in  ADDR_WIDTH  PC of resolved branch.
- i_update_taken  in  1  actual branch outcome.
- i_update_target  in  ADDR_WIDTH  actual branch target.

Behaviour:
- Address split:
  - index = pc[INDEX_WIDTH+1:2].
  - tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2].
  - pc[1:0] is ignored.
- Storage: per set and way, {valid, tag, target, ctr}; per set, ASSOCIATIVITY age values of $clog2(ASSOCIATIVITY) bits each, where 0 = MRU.
- Reset (async assertion):
  - All valid bits cleared, ctr = 01, age[w] = w.
  - All outputs 0.
  - Lookup or update in flight when reset asserts is discarded.
- Lookup, latency 1:
  - Compare tags across all ways of the indexed set; at most one way may match a valid entry.
  - Next cycle: o_hit, o_target, o_hit_way, o_pred_taken reflect the match.
  - If i_lookup_valid = 0, the outputs return 0 next cycle.
  - A lookup hit makes the hitting way MRU.
- Update, single cycle:
  - Hit, taken: ctr saturating-increment (max 2**CTR_WIDTH-1); target overwritten; way made MRU.
  - Hit, not-taken: ctr saturating-decrement (min 0); target unchanged; way made MRU.
  - Miss, taken: allocate. Victim is the lowest-index invalid way, else the way with maximum age. Write tag and target; ctr = 10; valid = 1; way made MRU.
  - Miss, not-taken: no state change.
- Age update when way w becomes MRU:
  - Ways with age < age[w] increment.
  - age[w] = 0; others unchanged.
  - Ages stay a permutation of 0..ASSOCIATIVITY-1 at all times.
- Simultaneous lookup and update to the same set:
  - Lookup sees pre-update contents (read-before-write) unless BTB_BYPASS_EN is defined.
  - Only the update's MRU touch is applied; the lookup touch is dropped.
- Flush:
  - Clears all valid bits next edge; ages and counters untouched.
  - Flush has priority over a same-cycle update, which is dropped.
  - A same-cycle lookup still returns pre-flush contents.

Optional Feature:
- Macro BTB_BYPASS_EN.
- Defined: a lookup that matches the same-cycle update's index and tag returns post-update values next cycle: hit = 1 if the update is taken or the entry already existed; target and ctr reflect the new values.
- Undefined: read-before-write as above.

Decomposition:
- Package btb_pkg: ctr_t typedef, saturating inc/dec functions, CTR_INIT_ALLOC = 2'b10, CTR_INIT_RST = 2'b01, tag/index extraction functions parametrised by widths.
- One sub-module, btb_lru_set: per-set age vector with a touch(way) input, victim output, and valid-aware victim selection. Instantiated DEPTH times via generate.

Test Plan:
- Reset, then lookup 0x0000_1000 -> next cycle o_hit = 0, o_target = 0, o_pred_taken = 0.
- Update pc 0x0000_1000, taken, target 0x0000_2000; then lookup 0x0000_1000 -> o_hit = 1, o_target = 0x0000_2000, o_pred_taken = 1, ctr = 10.
- Fill set 0 with 4 taken branches 0x0000_0000, 0x0000_0040, 0x0000_0080, 0x0000_00C0 (index 0); look up 0x0000_0000; allocate 0x0000_0100 -> the 0x0000_0040 way is evicted and 0x0000_0000 still hits.
- Two not-taken updates on a hit with ctr = 10 -> ctr = 00; a further not-taken update keeps 00; lookup gives o_hit = 1, o_pred_taken = 0.
- Same-cycle lookup and taken-allocate of 0x0000_3000 -> o_hit = 0 without BTB_BYPASS_EN; o_hit = 1, target correct with it.
- i_flush pulse with same-cycle update -> all later lookups miss; the update is not applied; rst asserted mid-update clears outputs asynchronously.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the N-way branch target buffer: counter type,
// counter init values, saturating counter arithmetic and PC field extraction.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT_ALLOC = 2'b10;
  localparam ctr_t CTR_INIT_RST   = 2'b01;

  function automatic logic [31:0] ctr_inc(input logic [31:0] c, input int w);
    return (c == (32'd1 << w) - 32'd1) ? c : c + 32'd1;
  endfunction

  function automatic logic [31:0] ctr_dec(input logic [31:0] c, input int w);
    return (c == 32'd0 || w == 0) ? c : c - 32'd1;
  endfunction

  // Word-aligned PC: index sits directly above the two byte-offset bits
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int iw);
    return (pc >> 2) & ((64'd1 << iw) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int iw);
    return pc >> (iw + 2);
  endfunction

endpackage

// File: rtl/btb_lru_set.sv
// True-LRU age tracker for one BTB set (age 0 = MRU) with valid-aware victim pick.
module btb_lru_set
  import btb_pkg::*;
#(
  parameter int WAYS = 4,
  localparam int WW = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            touch,
  input  logic [WW-1:0]   way,
  input  logic [WAYS-1:0] valid,
  output logic [WW-1:0]   victim
);

  logic [WAYS-1:0][WW-1:0] age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) age[w] <= WW'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == way) age[w] <= '0;
        else if (age[w] < age[way]) age[w] <= age[w] + WW'(1);
      end
    end
  end

  // Ages form a permutation, so the oldest way is the one holding WAYS-1
  always_comb begin
    logic found;
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++)
        if (age[w] == WW'(WAYS - 1)) victim = WW'(w);
    end
  end

endmodule

// File: rtl/btb_nway_predictor.sv
// N-way set-associative BTB with 2-bit direction counters and true-LRU replacement.
// Define BTB_BYPASS_EN to forward a same-cycle update to a matching lookup.
module btb_nway_predictor
  import btb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int INDEX_WIDTH   = 4,
  parameter int ASSOCIATIVITY = 4,
  parameter int CTR_WIDTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic                             i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0]            i_lookup_pc,
  output logic                             o_hit,
  output logic                             o_pred_taken,
  output logic [ADDR_WIDTH-1:0]            o_target,
  output logic [$clog2(ASSOCIATIVITY)-1:0] o_hit_way,
  input  logic                             i_update_valid,
  input  logic [ADDR_WIDTH-1:0]            i_update_pc,
  input  logic                             i_update_taken,
  input  logic [ADDR_WIDTH-1:0]            i_update_target
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int WAYS  = ASSOCIATIVITY;
  localparam int WW    = $clog2(WAYS);
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_ALLOC = CTR_WIDTH'(CTR_INIT_ALLOC) << (CTR_WIDTH - 2);
  localparam logic [CTR_WIDTH-1:0] CTR_RST   = CTR_ALLOC - CTR_WIDTH'(1);

  logic [DEPTH-1:0][WAYS-1:0] valid;
  logic [TAG_W-1:0]           tags    [DEPTH][WAYS];
  logic [ADDR_WIDTH-1:0]      targets [DEPTH][WAYS];
  logic [CTR_WIDTH-1:0]       ctrs    [DEPTH][WAYS];
  logic [WW-1:0]              victim    [DEPTH];
  logic [WW-1:0]              touch_way [DEPTH];
  logic [DEPTH-1:0]           touch;

  logic [INDEX_WIDTH-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]       lk_tag, up_tag;
  logic                   lk_hit, up_hit, up_touch, bypass, byp_hit;
  logic [WW-1:0]          lk_way, up_hit_way, up_way;
  logic [CTR_WIDTH-1:0]   new_ctr;
  logic [ADDR_WIDTH-1:0]  new_target;

  assign lk_idx = INDEX_WIDTH'(pc_index(64'(i_lookup_pc), INDEX_WIDTH));
  assign lk_tag = TAG_W'(pc_tag(64'(i_lookup_pc), INDEX_WIDTH));
  assign up_idx = INDEX_WIDTH'(pc_index(64'(i_update_pc), INDEX_WIDTH));
  assign up_tag = TAG_W'(pc_tag(64'(i_update_pc), INDEX_WIDTH));

  always_comb begin
    lk_hit     = 1'b0;
    lk_way     = '0;
    up_hit     = 1'b0;
    up_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[lk_idx][w] && tags[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WW'(w);
      end
      if (valid[up_idx][w] && tags[up_idx][w] == up_tag) begin
        up_hit     = 1'b1;
        up_hit_way = WW'(w);
      end
    end
  end

  // A not-taken miss leaves the table alone; everything else touches a way
  assign up_touch   = i_update_valid && !i_flush && (up_hit || i_update_taken);
  assign up_way     = up_hit ? up_hit_way : victim[up_idx];
  assign new_target = i_update_taken ? i_update_target : targets[up_idx][up_hit_way];

  always_comb begin
    new_ctr = CTR_ALLOC;
    if (up_hit)
      new_ctr = i_update_taken
        ? CTR_WIDTH'(ctr_inc(32'(ctrs[up_idx][up_hit_way]), CTR_WIDTH))
        : CTR_WIDTH'(ctr_dec(32'(ctrs[up_idx][up_hit_way]), CTR_WIDTH));
  end

  always_comb begin
`ifdef BTB_BYPASS_EN
    bypass = i_update_valid && !i_flush && up_idx == lk_idx && up_tag == lk_tag;
`else
    bypass = 1'b0;
`endif
  end
  assign byp_hit = up_hit || i_update_taken;

  for (genvar s = 0; s < DEPTH; s++) begin : g_set
    logic up_here, lk_here;
    // The update's MRU touch wins over a lookup touch on the same set
    assign up_here      = up_touch && up_idx == INDEX_WIDTH'(s);
    assign lk_here      = i_lookup_valid && lk_hit && lk_idx == INDEX_WIDTH'(s);
    assign touch[s]     = up_here || lk_here;
    assign touch_way[s] = up_here ? up_way : lk_way;

    btb_lru_set #(.WAYS(WAYS)) u_lru (
      .clk    (clk),
      .rst    (rst),
      .touch  (touch[s]),
      .way    (touch_way[s]),
      .valid  (valid[s]),
      .victim (victim[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tags[s][w]    <= '0;
          targets[s][w] <= '0;
          ctrs[s][w]    <= CTR_RST;
        end
      end
    end else if (i_flush) begin
      valid <= '0;
    end else if (up_touch) begin
      valid[up_idx][up_way]   <= 1'b1;
      tags[up_idx][up_way]    <= up_tag;
      targets[up_idx][up_way] <= new_target;
      ctrs[up_idx][up_way]    <= new_ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || !i_lookup_valid) begin
      o_hit        <= 1'b0;
      o_pred_taken <= 1'b0;
      o_target     <= '0;
      o_hit_way    <= '0;
    end else if (bypass) begin
      o_hit        <= byp_hit;
      o_pred_taken <= byp_hit && new_ctr[CTR_WIDTH-1];
      o_target     <= byp_hit ? new_target : '0;
      o_hit_way    <= byp_hit ? up_way : '0;
    end else begin
      o_hit        <= lk_hit;
      o_pred_taken <= lk_hit && ctrs[lk_idx][lk_way][CTR_WIDTH-1];
      o_target     <= lk_hit ? targets[lk_idx][lk_way] : '0;
      o_hit_way    <= lk_way;
    end
  end

endmodule

// File: tb/tb_btb_nway_predictor.sv
// Randomized self-checking bench for btb_nway_predictor against a recency-list reference model.
module tb_btb_nway_predictor;

`ifdef BTB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush, i_lookup_valid, i_update_valid, i_update_taken;
  logic [31:0] i_lookup_pc, i_update_pc, i_update_target;
  logic        o_hit, o_pred_taken;
  logic [31:0] o_target;
  logic [1:0]  o_hit_way;

  btb_nway_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .i_flush         (i_flush),
    .i_lookup_valid  (i_lookup_valid),
    .i_lookup_pc     (i_lookup_pc),
    .o_hit           (o_hit),
    .o_pred_taken    (o_pred_taken),
    .o_target        (o_target),
    .o_hit_way       (o_hit_way),
    .i_update_valid  (i_update_valid),
    .i_update_pc     (i_update_pc),
    .i_update_taken  (i_update_taken),
    .i_update_target (i_update_target)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Reference model: per set a recency list (position 0 = most recent)
  bit          mv    [16][4];
  logic [31:0] mtag  [16][4];
  logic [31:0] mtgt  [16][4];
  int          mctr  [16][4];
  int          morder[16][4];
  bit          ehit, epred;
  logic [31:0] etgt;
  int          eway;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        mv[s][w] = 1'b0; mtag[s][w] = '0; mtgt[s][w] = '0;
        mctr[s][w] = 1; morder[s][w] = w;
      end
  endtask

  task automatic mtouch(input int s, input int w);
    int p = 0;
    for (int k = 0; k < 4; k++) if (morder[s][k] == w) p = k;
    for (int k = p; k > 0; k--) morder[s][k] = morder[s][k-1];
    morder[s][0] = w;
  endtask

  task automatic model(input bit lv, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utg, input bit fl);
    int li = int'((lpc >> 2) & 32'hF), ui = int'((upc >> 2) & 32'hF);
    logic [31:0] lt = lpc >> 6, utag = upc >> 6, ntgt;
    bit lhit = 0, uhit = 0, utouch;
    int lway = 0, uway = 0, vic = -1, uw, nctr;
    for (int w = 0; w < 4; w++) begin
      if (mv[li][w] && mtag[li][w] == lt) begin lhit = 1; lway = w; end
      if (mv[ui][w] && mtag[ui][w] == utag) begin uhit = 1; uway = w; end
      if (!mv[ui][w] && vic < 0) vic = w;
    end
    if (vic < 0) vic = morder[ui][3];
    utouch = uv && !fl && (uhit || ut);
    uw   = uhit ? uway : vic;
    nctr = !uhit ? 2 : ut ? (mctr[ui][uw] == 3 ? 3 : mctr[ui][uw] + 1)
                          : (mctr[ui][uw] == 0 ? 0 : mctr[ui][uw] - 1);
    ntgt = ut ? utg : mtgt[ui][uw];
    ehit = 0; epred = 0; etgt = '0; eway = 0;
    if (lv) begin
      if (BYP && uv && !fl && ui == li && utag == lt) begin
        ehit = uhit || ut;
        if (ehit) begin eway = uw; etgt = ntgt; epred = nctr >= 2; end
      end else if (lhit) begin
        ehit = 1; eway = lway; etgt = mtgt[li][lway]; epred = mctr[li][lway] >= 2;
      end
    end
    if (lv && lhit && !(utouch && ui == li)) mtouch(li, lway);
    if (utouch) begin
      mv[ui][uw] = 1; mtag[ui][uw] = utag; mtgt[ui][uw] = ntgt; mctr[ui][uw] = nctr;
      mtouch(ui, uw);
    end
    if (fl) for (int s = 0; s < 16; s++) for (int w = 0; w < 4; w++) mv[s][w] = 0;
  endtask

  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input bit ut, input logic [31:0] utg, input bit fl);
    i_lookup_valid = lv; i_lookup_pc = lpc; i_update_valid = uv; i_update_pc = upc;
    i_update_taken = ut; i_update_target = utg; i_flush = fl;
    model(lv, lpc, uv, upc, ut, utg, fl);
    @(posedge clk); @(negedge clk);
    chk("hit", 64'(o_hit), 64'(ehit));
    chk("target", 64'(o_target), 64'(etgt));
    chk("way", 64'(o_hit_way), 64'(eway));
    chk("pred", 64'(o_pred_taken), 64'(epred));
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    step(0, 0, 1, pc, t, tg, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_flush = 0; i_lookup_valid = 0; i_update_valid = 0;
    i_lookup_pc = 0; i_update_pc = 0; i_update_taken = 0; i_update_target = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_hit", 64'(o_hit), 0);
    chk("rst_target", 64'(o_target), 0);
    chk("rst_way", 64'(o_hit_way), 0);
    chk("rst_pred", 64'(o_pred_taken), 0);
    rst = 1'b0;
    mreset();
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] t = $urandom_range(0, 5), s = $urandom_range(0, 3), b = $urandom_range(0, 3);
    return (t << 6) | (s << 2) | b;
  endfunction

  initial begin
    do_reset();
    lookup(32'h1000);
    update(32'h1000, 1, 32'h2000);
    lookup(32'h1000);
    chk("alloc_hit", 64'(o_hit), 1);

    // LRU eviction: fill set 0, refresh 0x0, then allocate a fifth branch
    do_reset();
    update(32'h0000, 1, 32'hA000);
    update(32'h0040, 1, 32'hA040);
    update(32'h0080, 1, 32'hA080);
    update(32'h00C0, 1, 32'hA0C0);
    lookup(32'h0000);
    update(32'h0100, 1, 32'hA100);
    lookup(32'h0040);
    chk("evicted", 64'(o_hit), 0);
    lookup(32'h0000);
    chk("kept", 64'(o_hit), 1);
    lookup(32'h0100);

    // Counter saturates at 0, then one taken update leaves it at 01
    update(32'h0000, 0, 0);
    update(32'h0000, 0, 0);
    update(32'h0000, 0, 0);
    lookup(32'h0000);
    chk("ctr_floor_pred", 64'(o_pred_taken), 0);
    update(32'h0000, 1, 32'hB000);
    lookup(32'h0000);

    // Same-cycle lookup and allocate
    step(1, 32'h3000, 1, 32'h3000, 1, 32'h4000, 0);
    chk("same_cycle_hit", 64'(o_hit), 64'(BYP));
    lookup(32'h3000);

    // Flush with same-cycle update and lookup
    step(1, 32'h3000, 1, 32'h5004, 1, 32'h6000, 1);
    chk("flush_pre_hit", 64'(o_hit), 1);
    lookup(32'h3000);
    lookup(32'h5004);
    chk("flush_upd_dropped", 64'(o_hit), 0);

    // Async reset during an update while the outputs show a hit
    update(32'h7000, 1, 32'h7700);
    lookup(32'h7000);
    i_lookup_valid = 1; i_lookup_pc = 32'h7000;
    i_update_valid = 1; i_update_pc = 32'h7040; i_update_taken = 1; i_update_target = 32'h1;
    #2 rst = 1'b1;
    #1 chk("async_rst_hit", 64'(o_hit), 0);
    chk("async_rst_target", 64'(o_target), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    mreset();
    lookup(32'h7000);
    lookup(32'h7040);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8, rpc(), $urandom_range(0, 1), rpc(),
           $urandom_range(0, 9) < 6, $urandom(), $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
